// File: rtl/cardinal_dmem_responder_if.sv
// cardinal_dmem_responder_if: core data-port bundle; parity signals exist only with CARDINAL_DMEM_PARITY_EN
interface cardinal_dmem_responder_if;
  logic        mem_en;
  logic        mem_wr_en;
  logic [0:31] mem_addr;
  logic [0:63] wr_data;
  logic [0:63] rd_data;
  logic        ready;
  logic        addr_err;
  logic        busy_err;
`ifdef CARDINAL_DMEM_PARITY_EN
  logic        par_inject;
  logic        par_err;
  modport master (output mem_en, mem_wr_en, mem_addr, wr_data, par_inject,
                  input rd_data, ready, addr_err, busy_err, par_err);
  modport slave (input mem_en, mem_wr_en, mem_addr, wr_data, par_inject,
                 output rd_data, ready, addr_err, busy_err, par_err);
`else
  modport master (output mem_en, mem_wr_en, mem_addr, wr_data,
                  input rd_data, ready, addr_err, busy_err);
  modport slave (input mem_en, mem_wr_en, mem_addr, wr_data,
                 output rd_data, ready, addr_err, busy_err);
`endif
endinterface

// File: rtl/cardinal_dmem_responder.sv
// cardinal_dmem_responder: 1-cycle data memory with post-reset clear sweep and sticky errors; CARDINAL_DMEM_PARITY_EN adds per-word parity
module cardinal_dmem_responder #(
  parameter int DEPTH          = 256,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input logic                     clk,
  input logic                     reset,
  cardinal_dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] clr_idx_q, clr_idx_d;
  logic [0:63]   rd_data_q, rd_data_d;
  logic          addr_err_q, addr_err_d;
  logic          busy_err_q, busy_err_d;
  logic [0:63]   mem_q [DEPTH];
  logic [31:0]   addr;
  logic [AW-1:0] idx, widx;
  logic          addr_ok, mem_we;
  logic [0:63]   wdata;
`ifdef CARDINAL_DMEM_PARITY_EN
  logic          par_q [DEPTH];
  logic          par_err_q, par_err_d, wpar;
`endif
  assign addr    = bus.mem_addr;
  assign idx     = addr[AW+2:3];
  assign addr_ok = (addr[2:0] == 3'd0) && ((addr >> (AW + 3)) == 32'd0);
  assign bus.rd_data  = rd_data_q;
  assign bus.ready    = state_q == RUN;
  assign bus.addr_err = addr_err_q;
  assign bus.busy_err = busy_err_q;
`ifdef CARDINAL_DMEM_PARITY_EN
  assign bus.par_err  = par_err_q;
`endif
  // Next state: sweep zeros during CLEAR, decode and service one access per cycle in RUN
  always_comb begin
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    rd_data_d  = rd_data_q;
    addr_err_d = addr_err_q;
    busy_err_d = busy_err_q;
    mem_we     = 1'b0;
    widx       = idx;
    wdata      = bus.wr_data;
`ifdef CARDINAL_DMEM_PARITY_EN
    par_err_d  = par_err_q;
    wpar       = 1'b0;
`endif
    if (state_q == CLEAR) begin
      mem_we     = 1'b1;
      widx       = clr_idx_q;
      wdata      = '0;
      clr_idx_d  = clr_idx_q + 1'b1;
      state_d    = &clr_idx_q ? RUN : CLEAR;
      busy_err_d = busy_err_q | bus.mem_en;
    end else if (bus.mem_en) begin
      addr_err_d = addr_err_q | ~addr_ok;
      mem_we     = bus.mem_wr_en & addr_ok;
      rd_data_d  = bus.mem_wr_en ? rd_data_q : addr_ok ? mem_q[idx] : '0;
`ifdef CARDINAL_DMEM_PARITY_EN
      wpar       = ^bus.wr_data ^ bus.par_inject;
      par_err_d  = par_err_q | (~bus.mem_wr_en & addr_ok & (^mem_q[idx] ^ par_q[idx]));
`endif
    end
  end
  // State and sticky flag registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= CLEAR_ON_RESET ? CLEAR : RUN;
      clr_idx_q  <= '0;
      rd_data_q  <= '0;
      addr_err_q <= 1'b0;
      busy_err_q <= 1'b0;
`ifdef CARDINAL_DMEM_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      rd_data_q  <= rd_data_d;
      addr_err_q <= addr_err_d;
      busy_err_q <= busy_err_d;
`ifdef CARDINAL_DMEM_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end
  // Storage array; never written while reset is held
  always_ff @(posedge clk) begin
    if (mem_we && !reset) mem_q[widx] <= wdata;
  end
`ifdef CARDINAL_DMEM_PARITY_EN
  // Parity bit per word, written alongside the data
  always_ff @(posedge clk) begin
    if (mem_we && !reset) par_q[widx] <= wpar;
  end
`endif
endmodule

// File: tb/tb_cardinal_dmem_responder.sv
// tb_cardinal_dmem_responder: randomized and directed checks against a behavioural memory model
module tb_cardinal_dmem_responder;
  localparam int DEPTH = 256;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int tests = 0;
  int fails = 0;
  logic [63:0] m_mem [DEPTH];
  logic        m_par [DEPTH];
  logic [63:0] m_rd;
  logic        m_aerr, m_berr, m_perr;
  int          m_cyc;
  cardinal_dmem_responder_if b();
  cardinal_dmem_responder #(.DEPTH(DEPTH), .CLEAR_ON_RESET(1'b1)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  always #5 clk = ~clk;

  task automatic step(input logic r, input logic en, input logic we, input logic [31:0] a, input logic [63:0] d, input logic inj);
    reset = r;
    b.mem_en = en;
    b.mem_wr_en = we;
    b.mem_addr = a;
    b.wr_data = d;
`ifdef CARDINAL_DMEM_PARITY_EN
    b.par_inject = inj;
`endif
    @(posedge clk);
    if (r) begin
      m_rd = 0; m_aerr = 0; m_berr = 0; m_perr = 0; m_cyc = 0;
      for (int i = 0; i < DEPTH; i++) begin m_mem[i] = 0; m_par[i] = 0; end
    end else if (m_cyc < DEPTH) begin
      m_cyc++;
      if (en) m_berr = 1;
    end else if (en) begin
      if (a % 8 != 0 || a >= DEPTH * 8) begin
        m_aerr = 1;
        if (!we) m_rd = 0;
      end else if (we) begin
        m_mem[a / 8] = d;
        m_par[a / 8] = ^d ^ inj;
      end else begin
        m_rd = m_mem[a / 8];
        if (^m_mem[a / 8] ^ m_par[a / 8]) m_perr = 1;
      end
    end
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!b.ready && n < 2000) begin idle(); n++; end
  endtask

  task automatic test_reset();
    int n;
    step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    tests++;
    if (b.rd_data !== 64'd0 || b.addr_err !== 1'b0 || b.busy_err !== 1'b0 || b.ready !== 1'b0) begin
      fails++; $display("FAIL reset_state rd=%h aerr=%b berr=%b ready=%b want 0/0/0/0", b.rd_data, b.addr_err, b.busy_err, b.ready);
    end
    wait_ready(n);
    tests++;
    if (n != 256) begin fails++; $display("FAIL sweep_len got %0d cycles want 256", n); end
    step(1'b0, 1'b1, 1'b0, 32'h10, 64'd0, 1'b0);
    tests++;
    if (b.rd_data !== 64'd0) begin fails++; $display("FAIL cleared_load got %h want 0", b.rd_data); end
  endtask

  task automatic test_store_load();
    step(1'b0, 1'b1, 1'b1, 32'h40, 64'hDEAD_BEEF_0123_4567, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h40, 64'd0, 1'b0);
    tests++;
    if (b.rd_data !== 64'hDEAD_BEEF_0123_4567) begin fails++; $display("FAIL store_load got %h want DEADBEEF01234567", b.rd_data); end
    for (int i = 0; i < 3; i++) begin
      idle();
      tests++;
      if (b.rd_data !== 64'hDEAD_BEEF_0123_4567) begin fails++; $display("FAIL hold_%0d got %h want DEADBEEF01234567", i, b.rd_data); end
    end
  endtask

  task automatic test_addr_err();
    step(1'b0, 1'b1, 1'b1, 32'h800, 64'h1, 1'b0);
    tests++;
    if (b.addr_err !== 1'b1) begin fails++; $display("FAIL oor_addr_err got %b want 1", b.addr_err); end
    step(1'b0, 1'b1, 1'b0, 32'h4, 64'd0, 1'b0);
    tests++;
    if (b.rd_data !== 64'd0) begin fails++; $display("FAIL misaligned_load got %h want 0", b.rd_data); end
    step(1'b0, 1'b1, 1'b0, 32'h0, 64'd0, 1'b0);
    tests++;
    if (b.rd_data !== 64'd0 || b.addr_err !== 1'b1) begin fails++; $display("FAIL oor_no_write rd=%h aerr=%b want 0/1", b.rd_data, b.addr_err); end
  endtask

  task automatic test_busy();
    int n;
    step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    for (int i = 0; i < 100; i++) idle();
    step(1'b0, 1'b1, 1'b0, 32'h40, 64'd0, 1'b0);
    tests++;
    if (b.busy_err !== 1'b1 || b.rd_data !== m_rd || b.ready !== 1'b0) begin
      fails++; $display("FAIL busy_load berr=%b rd=%h ready=%b want 1/%h/0", b.busy_err, b.rd_data, b.ready, m_rd);
    end
    wait_ready(n);
    tests++;
    if (n + 101 != 256) begin fails++; $display("FAIL busy_sweep_len got %0d want 256", n + 101); end
  endtask

  task automatic test_reset_mid();
    int n;
    step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    for (int i = 0; i < 50; i++) step(1'b0, i == 10, 1'b0, 32'h4, 64'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    tests++;
    if (b.busy_err !== 1'b0 || b.addr_err !== 1'b0 || b.ready !== 1'b0) begin
      fails++; $display("FAIL mid_reset_flags berr=%b aerr=%b ready=%b want 0/0/0", b.busy_err, b.addr_err, b.ready);
    end
    wait_ready(n);
    tests++;
    if (n != 256) begin fails++; $display("FAIL restart_sweep_len got %0d want 256", n); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      logic [31:0] a;
      logic [63:0] d;
      a = $urandom_range(0, DEPTH - 1) * 8;
      d = {$urandom, $urandom};
      step(1'b0, 1'b1, 1'b1, a, d, 1'b0);
      step(1'b0, 1'b1, 1'b0, a, 64'd0, 1'b0);
      tests++;
      if (b.rd_data !== d) begin fails++; $display("FAIL b2b addr=%h got %h want %h", a, b.rd_data, d); end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      int k;
      k = $urandom_range(0, 9);
      a = $urandom_range(0, 15) * 8;
      if (k == 8) a = a | $urandom_range(1, 7);
      if (k == 9) a = a + DEPTH * 8 * $urandom_range(1, 3);
      step(1'b0, $urandom_range(0, 3) != 0, $urandom_range(0, 1), a, {$urandom, $urandom}, 1'b0);
      tests++;
      if (b.rd_data !== m_rd || b.addr_err !== m_aerr || b.busy_err !== m_berr || b.ready !== (m_cyc >= DEPTH)) begin
        fails++; $display("FAIL random_%0d rd=%h aerr=%b berr=%b rdy=%b want %h/%b/%b/%b", i, b.rd_data, b.addr_err, b.busy_err, b.ready, m_rd, m_aerr, m_berr, m_cyc >= DEPTH);
      end
    end
  endtask

`ifdef CARDINAL_DMEM_PARITY_EN
  task automatic test_parity();
    int n;
    step(1'b1, 1'b0, 1'b0, 32'd0, 64'd0, 1'b0);
    wait_ready(n);
    step(1'b0, 1'b1, 1'b1, 32'h10, 64'h3, 1'b0);
    step(1'b0, 1'b1, 1'b0, 32'h10, 64'd0, 1'b0);
    tests++;
    if (b.rd_data !== 64'h3 || b.par_err !== 1'b0) begin fails++; $display("FAIL parity_clean rd=%h perr=%b want 3/0", b.rd_data, b.par_err); end
    step(1'b0, 1'b1, 1'b1, 32'h8, 64'hFF, 1'b1);
    step(1'b0, 1'b1, 1'b0, 32'h8, 64'd0, 1'b0);
    tests++;
    if (b.rd_data !== 64'hFF || b.par_err !== m_perr || m_perr !== 1'b1) begin
      fails++; $display("FAIL parity_inject rd=%h perr=%b want FF/1", b.rd_data, b.par_err);
    end
  endtask
`endif

  initial begin
    b.mem_en = 1'b0;
    b.mem_wr_en = 1'b0;
    b.mem_addr = '0;
    b.wr_data = '0;
`ifdef CARDINAL_DMEM_PARITY_EN
    b.par_inject = 1'b0;
`endif
    test_reset();
    test_store_load();
    test_addr_err();
    test_busy();
    test_reset_mid();
    test_back_to_back();
    test_random();
`ifdef CARDINAL_DMEM_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
